cnf_clause_evaluator: RTL and testbench
=======================================

// Module: cnf_clause_evaluator
// PURPOSE
//  Sequential responder for candidate-assignment requests from the solver. Accepts one NUM_VARS-bit
//  assignment over a valid/ready handshake and scans the selected 3-literal CNF formula, one clause
//  per clock. Returns SAT/UNSAT and the index of the first falsified clause.
//  Sits between the solver (initiator) and the formula store; replaces the single-cycle CNF path.
// PARAMETERS
//  NUM_VARS      3  variables per assignment; assign_in[NUM_VARS-1] is variable A (MSB-first)
//  NUM_CLAUSES   4  clauses per formula, indices 0..NUM_CLAUSES-1
//  NUM_FORMULAS  4  formulas in the table, addressed by sel
// PORTS
//  clk            in   1                      clock, all logic on rising edge
//  reset          in   1                      synchronous, active-high
//  sel            in   $clog2(NUM_FORMULAS)   formula select, sampled on request accept
//  req_valid      in   1                      assignment request valid
//  req_ready      out  1                      evaluator can accept a request
//  assign_in      in   NUM_VARS               candidate assignment, sampled on accept
//  resp_valid     out  1                      result valid
//  resp_ready     in   1                      solver consumes result
//  resp_sat       out  1                      1 = every clause satisfied
//  resp_fail_idx  out  $clog2(NUM_CLAUSES)    first falsified clause; 0 when resp_sat=1
//  sat_count      out  16                     SAT responses delivered since reset, saturating
// BEHAVIOUR
//  - Reset values: req_ready=1, resp_valid=0, resp_sat=0, resp_fail_idx=0, sat_count=0, state=IDLE.
//  - FSM IDLE->EVAL->RESP->IDLE. req_ready=1 only in IDLE. resp_valid=1 only in RESP.
//  - IDLE: on req_valid&&req_ready, latch assign_in and sel, clear the clause counter and sat flag,
//    then move to EVAL. The solver must not drive new data until the next accept.
//  - EVAL: evaluate clause[cnt] of the latched formula, one clause per cycle.
//  - Literal format: {en, neg, var_idx}. Literal value = en & (assign[var_idx] ^ neg).
//    Clause value = OR of its 3 literals. A clause with all literals disabled is FALSE.
//    A var_idx >= NUM_VARS reads as 0.
//  - On the first false clause, record cnt in fail_idx. Later false clauses do not overwrite it.
//  - Counter wraps cleanly: the last clause (cnt=NUM_CLAUSES-1) moves the FSM to RESP.
//  - Latency: accept at edge T, clauses evaluated at T+1..T+NUM_CLAUSES, resp_valid high from T+NUM_CLAUSES+1.
//  - RESP: hold resp_* stable until resp_ready. At the resp_valid&&resp_ready edge go to IDLE.
//    On that edge sat_count increments if resp_sat=1; it saturates at 16'hFFFF.
//  - resp_ready may be high before resp_valid; this has no effect. A request is never accepted in
//    the same cycle a response completes; req_ready rises the cycle after.
//  - sel/assign_in changes during EVAL or RESP are ignored.
//  - Reset mid-EVAL or mid-RESP: the in-flight result is dropped, no response is issued, and all
//    outputs return to reset values.
// CONFIGURATION
//  EARLY_EXIT_EN defined: on the first false clause, EVAL goes directly to RESP (UNSAT).
//    Failing clause k gives resp_valid at T+k+2. SAT latency is unchanged.
//  EARLY_EXIT_EN undefined: always scans all clauses, fixed latency NUM_CLAUSES+1.
//  Result values are identical in both builds.
// STRUCTURE
//  Package cnf_pkg:
//    - literal typedef {en, neg, var_idx} and clause typedef (3 literals)
//    - FSM state enum (IDLE/EVAL/RESP)
//    - formula table constants: FORMULA_0..3
//  Sub-module cnf_formula_rom is combinational: (sel, clause_idx) -> clause.
//    F0 = (A|B|C)&(~A|B)&(~B|C)&(~A|~C).
//    F3 has all literals disabled.
// TESTING
//  1. sel=0, assign=3'b011, resp_ready=1 -> resp_valid at T+5, resp_sat=1, fail_idx=0, sat_count=1.
//  2. sel=0, assign=3'b111 -> resp_sat=0, fail_idx=3. With EARLY_EXIT_EN: resp at T+5 (k=3).
//  3. sel=0, assign=3'b000 -> resp_sat=0, fail_idx=0. Latency T+5 (no EARLY_EXIT_EN) or T+2 (with).
//  4. Hold resp_ready=0 for 10 cycles -> resp_* stable, req_ready=0, second req_valid not accepted.
//     sat_count changes only on the handshake.
//  5. Assert reset at T+2 mid-EVAL -> no resp_valid, req_ready=1 the next cycle, sat_count=0.
//     A fresh request then completes normally.
//  6. sel=3, any assign -> resp_sat=0, fail_idx=0. Force sat_count=16'hFFFF, then a SAT response ->
//     sat_count remains 16'hFFFF.

Source files
------------

// File: rtl/cnf_pkg.sv
// Shared types and constants for the CNF clause evaluator: literal and
// clause encodings, the evaluator FSM states and the formula table.
package cnf_pkg;

  localparam int NUM_VARS     = 3;
  localparam int NUM_CLAUSES  = 4;
  localparam int NUM_FORMULAS = 4;
  localparam int LITS         = 3;

  localparam int VAR_W = $clog2(NUM_VARS);
  localparam int SEL_W = $clog2(NUM_FORMULAS);
  localparam int CNT_W = $clog2(NUM_CLAUSES);
  // Assignment zero-extended to every index a var_idx field can hold, so
  // out-of-range variables read as 0 without a separate range check.
  localparam int PAD_W = 1 << VAR_W;

  typedef struct packed {
    logic             en;
    logic             neg;
    logic [VAR_W-1:0] var_idx;
  } literal_t;

  typedef literal_t [0:LITS-1]        clause_t;
  typedef clause_t  [0:NUM_CLAUSES-1] formula_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_t;

  // Variable A is the assignment MSB, C the LSB; index 3 is out of range.
  localparam literal_t LIT_OFF = '{1'b0, 1'b0, VAR_W'(0)};
  localparam literal_t POS_A   = '{1'b1, 1'b0, VAR_W'(2)};
  localparam literal_t NEG_A   = '{1'b1, 1'b1, VAR_W'(2)};
  localparam literal_t POS_B   = '{1'b1, 1'b0, VAR_W'(1)};
  localparam literal_t NEG_B   = '{1'b1, 1'b1, VAR_W'(1)};
  localparam literal_t POS_C   = '{1'b1, 1'b0, VAR_W'(0)};
  localparam literal_t NEG_C   = '{1'b1, 1'b1, VAR_W'(0)};
  localparam literal_t POS_X   = '{1'b1, 1'b0, VAR_W'(3)};
  localparam literal_t NEG_X   = '{1'b1, 1'b1, VAR_W'(3)};

  // (A|B|C) & (~A|B) & (~B|C) & (~A|~C)
  localparam formula_t FORMULA_0 = '{
    '{POS_A, POS_B, POS_C},
    '{NEG_A, POS_B, LIT_OFF},
    '{NEG_B, POS_C, LIT_OFF},
    '{NEG_A, NEG_C, LIT_OFF}
  };
  // (A|~B|X) & (B|C) & (~X) & (~A|~B|~C)
  localparam formula_t FORMULA_1 = '{
    '{POS_A, NEG_B, POS_X},
    '{POS_B, POS_C, LIT_OFF},
    '{NEG_X, LIT_OFF, LIT_OFF},
    '{NEG_A, NEG_B, NEG_C}
  };
  // (A) & (~A|C) & (X|B) & (~C|B|~A)
  localparam formula_t FORMULA_2 = '{
    '{POS_A, LIT_OFF, LIT_OFF},
    '{NEG_A, POS_C, LIT_OFF},
    '{POS_X, POS_B, LIT_OFF},
    '{NEG_C, POS_B, NEG_A}
  };
  // Every literal disabled: every clause is false.
  localparam formula_t FORMULA_3 = '0;

  // OR of the enabled literals of one clause under the given assignment.
  function automatic logic clause_value(clause_t c, logic [NUM_VARS-1:0] a);
    logic [PAD_W-1:0] padded;
    logic             v;
    padded = PAD_W'(a);
    v      = 1'b0;
    for (int i = 0; i < LITS; i++) begin
      v = v | (c[i].en & (padded[c[i].var_idx] ^ c[i].neg));
    end
    return v;
  endfunction

endpackage

// File: rtl/cnf_formula_rom.sv
// Combinational formula table: (sel, clause_idx) -> clause.
module cnf_formula_rom
  import cnf_pkg::*;
(
  input  logic [SEL_W-1:0] sel,
  input  logic [CNT_W-1:0] clause_idx,
  output clause_t          clause
);

  // Select one clause of the addressed formula.
  always_comb begin
    // NOTE: default assignment first so no path leaves clause unassigned (no latch).
    clause = '0;
    case (sel)
      SEL_W'(0): clause = FORMULA_0[clause_idx];
      SEL_W'(1): clause = FORMULA_1[clause_idx];
      SEL_W'(2): clause = FORMULA_2[clause_idx];
      SEL_W'(3): clause = FORMULA_3[clause_idx];
      default:   clause = '0;
    endcase
  end

endmodule

// File: rtl/cnf_clause_evaluator.sv
// Sequential CNF evaluator: accepts an assignment, scans the selected
// formula one clause per clock and returns SAT/UNSAT plus the first
// falsified clause. Optional macro EARLY_EXIT_EN ends the scan at the
// first false clause; results are identical either way.
module cnf_clause_evaluator
  import cnf_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [SEL_W-1:0]    sel,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [NUM_VARS-1:0] assign_in,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic                resp_sat,
  output logic [CNT_W-1:0]    resp_fail_idx,
  output logic [15:0]         sat_count
);

  state_t              state, state_next;
  logic [CNT_W-1:0]    cnt;
  logic [SEL_W-1:0]    sel_q;
  logic [NUM_VARS-1:0] assign_q;
  logic                fail_seen;
  clause_t             clause;
  logic                clause_true;
  logic                last_clause;
  logic                accept;
  logic                complete;

  cnf_formula_rom u_rom (
    .sel        (sel_q),
    .clause_idx (cnt),
    .clause     (clause)
  );

  assign clause_true = clause_value(clause, assign_q);
  assign last_clause = (cnt == CNT_W'(NUM_CLAUSES - 1));
  assign accept      = (state == IDLE) && req_valid;
  assign complete    = (state == RESP) && resp_ready;
  assign resp_sat    = (state == RESP) && !fail_seen;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = EVAL;
      end
      EVAL: begin
`ifdef EARLY_EXIT_EN
        if (!clause_true || last_clause) state_next = RESP;
`else
        if (last_clause) state_next = RESP;
`endif
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request capture, clause scan bookkeeping and the SAT counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q         <= '0;
      assign_q      <= '0;
      cnt           <= '0;
      fail_seen     <= 1'b0;
      resp_fail_idx <= '0;
      sat_count     <= '0;
    end else begin
      if (accept) begin
        sel_q         <= sel;
        assign_q      <= assign_in;
        cnt           <= '0;
        fail_seen     <= 1'b0;
        resp_fail_idx <= '0;
      end
      if (state == EVAL) begin
        cnt <= cnt + 1'b1;
        // Only the first false clause is recorded.
        if (!clause_true && !fail_seen) begin
          fail_seen     <= 1'b1;
          resp_fail_idx <= cnt;
        end
      end
      if (complete && !fail_seen && (sat_count != 16'hFFFF)) begin
        sat_count <= sat_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_cnf_clause_evaluator.sv
// Self-checking bench for cnf_clause_evaluator: directed cases plus random
// requests, compared every cycle against a transaction-level model.
module tb_cnf_clause_evaluator;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  sel = '0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  assign_in = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic        resp_sat;
  logic [1:0]  resp_fail_idx;
  logic [15:0] sat_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cnf_clause_evaluator dut (
    .clk           (clk),
    .reset         (reset),
    .sel           (sel),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .assign_in     (assign_in),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_sat      (resp_sat),
    .resp_fail_idx (resp_fail_idx),
    .sat_count     (sat_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Formulas in DIMACS style: +n / -n is variable n (1=A, 2=B, 3=C, 4=out of range), 0 = unused.
  int ftbl [4][4][3] = '{
    '{'{1, 2, 3},   '{-1, 2, 0}, '{-2, 3, 0}, '{-1, -3, 0}},
    '{'{1, -2, 4},  '{2, 3, 0},  '{-4, 0, 0}, '{-1, -2, -3}},
    '{'{1, 0, 0},   '{-1, 3, 0}, '{4, 2, 0},  '{-3, 2, -1}},
    '{'{0, 0, 0},   '{0, 0, 0},  '{0, 0, 0},  '{0, 0, 0}}
  };

  function automatic bit lit_val(input int l, input logic [2:0] a);
    int v;
    bit x;
    if (l == 0) return 1'b0;
    v = (l < 0) ? -l : l;
    x = (v >= 1 && v <= 3) ? a[3 - v] : 1'b0;
    return (l < 0) ? !x : x;
  endfunction

  task automatic model_eval(input int s, input logic [2:0] a, output bit sat, output int fail);
    sat  = 1'b1;
    fail = 0;
    for (int c = 0; c < 4; c++) begin
      bit t;
      t = 1'b0;
      for (int l = 0; l < 3; l++) t = t | lit_val(ftbl[s][c][l], a);
      if (!t && sat) begin
        sat  = 1'b0;
        fail = c;
      end
    end
  endtask

  // Cycles from the accept cycle to the first cycle with resp_valid.
  function automatic int exp_lat(input bit sat, input int fail);
`ifdef EARLY_EXIT_EN
    return sat ? 5 : fail + 2;
`else
    return 5;
`endif
  endfunction

  // Transaction-level model state.
  bit          m_live = 1'b0;
  bit          m_busy = 1'b0;
  bit          m_resp = 1'b0;
  bit          m_sat  = 1'b0;
  int          m_fail = 0;
  int          m_wait = 0;
  logic [15:0] m_sat_count = '0;
  int          force_req = 0;
  int          force_seen = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_live = 1'b1;
      m_busy = 1'b0;
      m_resp = 1'b0;
      m_sat  = 1'b0;
      m_fail = 0;
      m_sat_count = '0;
      force_seen = force_req;
    end else if (m_live) begin
      if (force_req != force_seen) begin
        force_seen  = force_req;
        m_sat_count = 16'hFFFF;
      end
      if (m_resp) begin
        if (resp_ready) begin
          m_resp = 1'b0;
          if (m_sat && m_sat_count != 16'hFFFF) m_sat_count = m_sat_count + 16'd1;
        end
      end else if (m_busy) begin
        m_wait--;
        if (m_wait == 0) begin
          m_busy = 1'b0;
          m_resp = 1'b1;
        end
      end else if (req_valid) begin
        model_eval(int'(sel), assign_in, m_sat, m_fail);
        m_wait = exp_lat(m_sat, m_fail) - 1;
        m_busy = 1'b1;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_live) begin
      check("req_ready", 32'(req_ready), 32'(!m_busy && !m_resp));
      check("resp_valid", 32'(resp_valid), 32'(m_resp));
      if (m_resp) begin
        check("resp_sat", 32'(resp_sat), 32'(m_sat));
        check("resp_fail_idx", 32'(resp_fail_idx), 32'(m_fail));
      end
      check("sat_count", 32'(sat_count), 32'(m_sat_count));
    end
  end

  task automatic run_txn(input logic [1:0] s, input logic [2:0] a, input int hold,
                         input bit early_ready, output int lat, output bit rs, output int rf);
    int guard;
    @(negedge clk);
    sel        = s;
    assign_in  = a;
    req_valid  = 1'b1;
    resp_ready = early_ready;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) check("accept_timeout", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    sel       = 2'($urandom);
    assign_in = 3'($urandom);
    lat   = 1;
    guard = 0;
    while (!resp_valid && guard < 50) begin
      @(negedge clk);
      lat++;
      guard++;
    end
    if (!resp_valid) check("resp_timeout", 32'(resp_valid), 32'd1);
    rs = resp_sat;
    rf = int'(resp_fail_idx);
    if (!early_ready) begin
      repeat (hold) begin
        req_valid = 1'b1;
        sel       = 2'($urandom);
        assign_in = 3'($urandom);
        @(negedge clk);
      end
      resp_ready = 1'b1;
    end
    @(negedge clk);
    req_valid  = 1'b0;
    resp_ready = 1'b0;
  endtask

  initial begin
    int  lat, rf, mf;
    bit  rs, ms;
    logic [1:0] s;
    logic [2:0] a;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_sat", 32'(resp_sat), 32'd0);
    check("rst_fail_idx", 32'(resp_fail_idx), 32'd0);
    check("rst_sat_count", 32'(sat_count), 32'd0);

    // Pin the model with hand-derived results.
    model_eval(0, 3'b011, ms, mf); check("model_f0_011", 32'(ms), 32'd1);
    model_eval(0, 3'b111, ms, mf); check("model_f0_111", 32'(mf), 32'd3);
    model_eval(0, 3'b000, ms, mf); check("model_f0_000", 32'(mf), 32'd0);
    model_eval(1, 3'b000, ms, mf); check("model_f1_000", 32'(mf), 32'd1);
    model_eval(3, 3'b101, ms, mf); check("model_f3_sat", 32'(ms), 32'd0);

    // SAT case.
    run_txn(2'd0, 3'b011, 0, 1'b1, lat, rs, rf);
    check("t1_latency", 32'(lat), 32'd5);
    check("t1_sat", 32'(rs), 32'd1);
    check("t1_fail_idx", 32'(rf), 32'd0);
    check("t1_sat_count", 32'(sat_count), 32'd1);

    // Last clause false.
    run_txn(2'd0, 3'b111, 0, 1'b1, lat, rs, rf);
    check("t2_latency", 32'(lat), 32'd5);
    check("t2_sat", 32'(rs), 32'd0);
    check("t2_fail_idx", 32'(rf), 32'd3);

    // First clause false.
    run_txn(2'd0, 3'b000, 0, 1'b1, lat, rs, rf);
`ifdef EARLY_EXIT_EN
    check("t3_latency", 32'(lat), 32'd2);
`else
    check("t3_latency", 32'(lat), 32'd5);
`endif
    check("t3_fail_idx", 32'(rf), 32'd0);
    check("t3_sat_count", 32'(sat_count), 32'd1);

    // Back-pressure: response held for 10 cycles with a competing request.
    run_txn(2'd0, 3'b011, 10, 1'b0, lat, rs, rf);
    check("t4_sat", 32'(rs), 32'd1);
    check("t4_sat_count", 32'(sat_count), 32'd2);

    // Reset in the middle of a scan.
    @(negedge clk);
    sel = 2'd0; assign_in = 3'b011; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t5_req_ready", 32'(req_ready), 32'd1);
    check("t5_resp_valid", 32'(resp_valid), 32'd0);
    check("t5_sat_count", 32'(sat_count), 32'd0);
    repeat (6) @(negedge clk);
    run_txn(2'd0, 3'b011, 0, 1'b1, lat, rs, rf);
    check("t5_fresh_latency", 32'(lat), 32'd5);
    check("t5_fresh_sat_count", 32'(sat_count), 32'd1);

    // Randomised requests.
    for (int i = 0; i < 200; i++) begin
      s = 2'($urandom);
      a = 3'($urandom);
      run_txn(s, a, int'($urandom_range(0, 3)), 1'($urandom), lat, rs, rf);
      model_eval(int'(s), a, ms, mf);
      check("rnd_sat", 32'(rs), 32'(ms));
      check("rnd_fail_idx", 32'(rf), 32'(mf));
      check("rnd_latency", 32'(lat), 32'(exp_lat(ms, mf)));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    // All-disabled formula.
    run_txn(2'd3, 3'($urandom), 0, 1'b1, lat, rs, rf);
    check("t6_f3_sat", 32'(rs), 32'd0);
    check("t6_f3_fail_idx", 32'(rf), 32'd0);

    // Counter saturation.
    @(negedge clk);
    #2;
    force dut.sat_count = 16'hFFFF;
    force_req++;
    #1;
    release dut.sat_count;
    run_txn(2'd0, 3'b011, 0, 1'b1, lat, rs, rf);
    check("t6_sat", 32'(rs), 32'd1);
    check("t6_saturated", 32'(sat_count), 32'hFFFF);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
